// File: rtl/reg_incr_pipe_pkg.sv
// Shared AES datapath definitions: default word width, overflow modes and
// the per-stage control encoding used by the elastic pipeline stages.
package aes_defs;

    localparam int AES_DATA_W = 32;

    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

    typedef enum logic [1:0] {
        CTL_HOLD  = 2'd0,
        CTL_LOAD  = 2'd1,
        CTL_CLEAR = 2'd2
    } stage_ctl_e;

endpackage

// File: rtl/reg_incr_pipe_if.sv
// Valid/ready bus of reg_incr_pipe: upstream word entry and downstream
// delivery of {data, incremented data, overflow}.
interface reg_incr_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_inc;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inc, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inc, out_ovf
    );
endinterface

// File: rtl/reg_incr_pipe_stage.sv
// One elastic register stage. It accepts whenever it is empty or draining
// this cycle, so a full chain moves one word per cycle without bubbles.
module pipe_stage
    import aes_defs::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    stage_ctl_e   ctl;

    always_comb begin
        up_ready = !valid_q || dn_ready;
        ctl      = CTL_HOLD;
        if (up_valid && up_ready)   ctl = CTL_LOAD;
        else if (valid_q && dn_ready) ctl = CTL_CLEAR;

        valid_d = valid_q;
        data_d  = data_q;
        case (ctl)
            CTL_LOAD: begin
                valid_d = 1'b1;
                data_d  = up_data;
            end
            // payload is left stale when vacated; only valid matters
            CTL_CLEAR: valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
endmodule

// File: rtl/reg_incr_pipe.sv
// Elastic DEPTH-stage pipeline carrying a word together with word+INC
// (wrapping or saturating) and the carry-out, plus an occupancy count.
module reg_incr_pipe
    import aes_defs::*;
#(
    parameter int          WIDTH = AES_DATA_W,
    parameter int          DEPTH = 2,
    parameter int unsigned INC   = 1,
    parameter int          SAT   = SAT_WRAP,
    localparam int         CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    reg_incr_pipe_if.slave   bus,
    output logic [CNT_W-1:0] count
);
    localparam int PW = 2 * WIDTH + 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] inc_val;
    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    logic             vld [DEPTH+1];
    logic             rdy [DEPTH+1];
    logic [PW-1:0]    pay [DEPTH+1];

    // sum kept one bit wider so the carry-out is the overflow flag
    always_comb begin
        sum     = {1'b0, bus.in_data} + (WIDTH+1)'(INC);
        inc_val = sum[WIDTH-1:0];
        if (SAT == SAT_SAT && sum[WIDTH]) inc_val = '1;
    end

    assign vld[0]     = bus.in_valid;
    assign pay[0]     = {sum[WIDTH], inc_val, bus.in_data};
    assign rdy[DEPTH] = bus.out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (pay[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (pay[k+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[DEPTH];
    assign {bus.out_ovf, bus.out_inc, bus.out_data} = pay[DEPTH];

    always_comb begin
        in_xfer  = bus.in_valid && rdy[0];
        out_xfer = vld[DEPTH] && bus.out_ready;
        count_d  = count_q;
        if (in_xfer && !out_xfer)      count_d = count_q + 1'b1;
        else if (!in_xfer && out_xfer) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: tb/tb_reg_incr_pipe.sv
// Bench for reg_incr_pipe: four parameterisations driven from one initial
// block; streaming tests compare against a queue of model results.
module tb_reg_incr_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] i;
        logic        o;
    } exp_t;

    logic clk;
    logic rst;
    logic       cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [2:0] cnt_d;
    int checks = 0;
    int errors = 0;

    reg_incr_pipe_if #(.WIDTH(2))  ifa ();
    reg_incr_pipe_if #(.WIDTH(2))  ifb ();
    reg_incr_pipe_if #(.WIDTH(32)) ifc ();
    reg_incr_pipe_if #(.WIDTH(8))  ifd ();

    reg_incr_pipe #(.WIDTH(2),  .DEPTH(1), .INC(1), .SAT(0)) u_a (.clk(clk), .rst(rst), .bus(ifa), .count(cnt_a));
    reg_incr_pipe #(.WIDTH(2),  .DEPTH(1), .INC(1), .SAT(1)) u_b (.clk(clk), .rst(rst), .bus(ifb), .count(cnt_b));
    reg_incr_pipe #(.WIDTH(32), .DEPTH(3), .INC(1), .SAT(0)) u_c (.clk(clk), .rst(rst), .bus(ifc), .count(cnt_c));
    reg_incr_pipe #(.WIDTH(8),  .DEPTH(4), .INC(5), .SAT(1)) u_d (.clk(clk), .rst(rst), .bus(ifd), .count(cnt_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input int w, input int unsigned inc, input bit sat);
        exp_t r;
        logic [63:0] s, mask;
        s    = {32'd0, x} + {32'd0, inc};
        mask = (64'd1 << w) - 64'd1;
        r.d  = x;
        r.o  = s[w];
        r.i  = (sat && r.o) ? mask[31:0] : (s[31:0] & mask[31:0]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {ifa.in_valid, ifb.in_valid, ifc.in_valid, ifd.in_valid} = '0;
        {ifa.out_ready, ifb.out_ready, ifc.out_ready, ifd.out_ready} = '0;
        ifa.in_data = '0; ifb.in_data = '0; ifc.in_data = '0; ifd.in_data = '0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (cnt_c !== 2'd0) begin errors++; $display("FAIL reset_count_c: got %0d expected 0", cnt_c); end
        checks++; if (cnt_d !== 3'd0) begin errors++; $display("FAIL reset_count_d: got %0d expected 0", cnt_d); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ifc.in_ready); end
        checks++; if ({ifc.out_data, ifc.out_inc, ifc.out_ovf} !== 65'd0) begin
            errors++; $display("FAIL reset_payload: got %h/%h/%b expected 0/0/0", ifc.out_data, ifc.out_inc, ifc.out_ovf); end
        checks++; if ({ifa.out_valid, ifa.in_ready, cnt_a} !== 3'b010) begin
            errors++; $display("FAIL reset_a: got valid/ready/count %b expected 010", {ifa.out_valid, ifa.in_ready, cnt_a}); end
    endtask

    task automatic test_small_incr();
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
        ifa.in_valid = 1'b1;  ifa.in_data = 2'b01;
        ifb.in_valid = 1'b1;  ifb.in_data = 2'b11;
        step();
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        #1;
        checks++; if ({ifa.out_valid, ifa.out_data, ifa.out_inc, ifa.out_ovf} !== 6'b1_01_10_0) begin
            errors++; $display("FAIL small_01: got v/d/i/o %b expected 1_01_10_0", {ifa.out_valid, ifa.out_data, ifa.out_inc, ifa.out_ovf}); end
        checks++; if ({ifb.out_valid, ifb.out_data, ifb.out_inc, ifb.out_ovf} !== 6'b1_11_11_1) begin
            errors++; $display("FAIL small_sat_11: got v/d/i/o %b expected 1_11_11_1", {ifb.out_valid, ifb.out_data, ifb.out_inc, ifb.out_ovf}); end
        checks++; if (cnt_a !== 1'b1) begin errors++; $display("FAIL small_count: got %0d expected 1", cnt_a); end
        ifa.in_valid = 1'b1; ifa.in_data = 2'b11;
        step();
        ifa.in_valid = 1'b0;
        #1;
        checks++; if ({ifa.out_valid, ifa.out_data, ifa.out_inc, ifa.out_ovf} !== 6'b1_11_00_1) begin
            errors++; $display("FAIL small_wrap_11: got v/d/i/o %b expected 1_11_00_1", {ifa.out_valid, ifa.out_data, ifa.out_inc, ifa.out_ovf}); end
        step();
        #1;
        checks++; if ({ifa.out_valid, ifb.out_valid, cnt_a} !== 3'b000) begin
            errors++; $display("FAIL small_drain: got %b expected 000", {ifa.out_valid, ifb.out_valid, cnt_a}); end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int sent = 0, got = 0, first = -1, acc0 = -1;
        ifc.out_ready = 1'b1;
        for (int t = 0; t < 40 && got < 10; t++) begin
            ifc.in_valid = (sent < 10);
            ifc.in_data  = 32'(sent);
            #1;
            if (ifc.out_valid) begin
                if (first < 0) first = t;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL b2b_extra_word: got data %h with empty queue", ifc.out_data); end
                else begin
                    e = q.pop_front();
                    if ({ifc.out_data, ifc.out_inc, ifc.out_ovf} !== {e.d, e.i, e.o}) begin
                        errors++; $display("FAIL b2b_word: got %h/%h/%b expected %h/%h/%b", ifc.out_data, ifc.out_inc, ifc.out_ovf, e.d, e.i, e.o); end
                end
                checks++; if (t !== first + got) begin errors++; $display("FAIL b2b_rate: word %0d at cycle %0d expected %0d", got, t, first + got); end
                got++;
            end
            if (ifc.in_valid) begin
                checks++;
                if (!ifc.in_ready) begin errors++; $display("FAIL b2b_in_ready: got 0 expected 1 at cycle %0d", t); end
                else begin
                    q.push_back(model(ifc.in_data, 32, 1, 1'b0));
                    if (acc0 < 0) acc0 = t;
                    sent++;
                end
            end
            step();
        end
        ifc.in_valid = 1'b0;
        checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count: got %0d words expected 10", got); end
        checks++; if (first - acc0 !== 3) begin errors++; $display("FAIL b2b_latency: got %0d cycles expected 3", first - acc0); end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int sent = 0;
        ifc.out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 32'(100 + sent);
            #1;
            if (ifc.in_ready) begin q.push_back(model(ifc.in_data, 32, 1, 1'b0)); sent++; end
            step();
        end
        ifc.in_data = 32'(100 + sent);
        #1;
        checks++; if (sent !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", sent); end
        checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", ifc.in_ready); end
        checks++; if (cnt_c !== 2'd3) begin errors++; $display("FAIL bp_count_full: got %0d expected 3", cnt_c); end
        step();
        #1;
        checks++; if ({ifc.out_valid, ifc.out_data, ifc.out_inc} !== {1'b1, 32'd100, 32'd101}) begin
            errors++; $display("FAIL bp_stall_hold: got v/d/i %b/%0d/%0d expected 1/100/101", ifc.out_valid, ifc.out_data, ifc.out_inc); end
        ifc.out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            ifc.in_data = 32'(100 + sent);
            #1;
            checks++; if (cnt_c !== 2'd3) begin errors++; $display("FAIL bp_count_steady: got %0d expected 3", cnt_c); end
            checks++;
            if (!(ifc.out_valid && ifc.in_ready)) begin
                errors++; $display("FAIL bp_throughput: got valid/ready %b%b expected 11", ifc.out_valid, ifc.in_ready); end
            if (ifc.out_valid) begin
                e = q.pop_front();
                checks++; if ({ifc.out_data, ifc.out_inc, ifc.out_ovf} !== {e.d, e.i, e.o}) begin
                    errors++; $display("FAIL bp_word: got %0d/%0d/%b expected %0d/%0d/%b", ifc.out_data, ifc.out_inc, ifc.out_ovf, e.d, e.i, e.o); end
            end
            if (ifc.in_ready) begin q.push_back(model(ifc.in_data, 32, 1, 1'b0)); sent++; end
            step();
        end
        ifc.in_valid = 1'b0;
        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            #1;
            if (ifc.out_valid) begin
                e = q.pop_front();
                checks++; if ({ifc.out_data, ifc.out_inc, ifc.out_ovf} !== {e.d, e.i, e.o}) begin
                    errors++; $display("FAIL bp_drain_word: got %0d/%0d/%b expected %0d/%0d/%b", ifc.out_data, ifc.out_inc, ifc.out_ovf, e.d, e.i, e.o); end
            end
            step();
        end
        #1;
        checks++; if (q.size() !== 0 || cnt_c !== 2'd0) begin
            errors++; $display("FAIL bp_drain_empty: got %0d pending count %0d expected 0/0", q.size(), cnt_c); end
    endtask

    task automatic test_mid_reset();
        int lat = -1;
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 32'h1234_5678; step();
        ifc.in_data   = 32'h0BAD_F00D; step();
        ifc.in_valid  = 1'b0;
        #1;
        checks++; if (cnt_c !== 2'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", cnt_c); end
        rst = 1'b1; step(); rst = 1'b0;
        #1;
        checks++; if ({cnt_c, ifc.out_valid, ifc.in_ready} !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_state: got count/valid/ready %b expected 0001", {cnt_c, ifc.out_valid, ifc.in_ready}); end
        checks++; if (ifc.out_data !== 32'd0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", ifc.out_data); end
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 32'hFFFF_FFFF;
        step();
        ifc.in_valid  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (ifc.out_valid) begin lat = k; break; end
            step();
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rst_post_latency: got %0d expected 2", lat); end
        checks++; if ({ifc.out_data, ifc.out_inc, ifc.out_ovf} !== {32'hFFFF_FFFF, 32'd0, 1'b1}) begin
            errors++; $display("FAIL rst_post_word: got %h/%h/%b expected ffffffff/00000000/1", ifc.out_data, ifc.out_inc, ifc.out_ovf); end
        step();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int sent = 0, got = 0, occ = 0;
        logic inx, outx;
        for (int t = 0; t < 20000 && got < 1000; t++) begin
            ifd.in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            ifd.out_ready = ($urandom_range(0, 1) == 1);
            ifd.in_data   = 8'($urandom_range(0, 255));
            #1;
            checks++; if (cnt_d !== 3'(occ)) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", cnt_d, occ); end
            checks++; if (ifd.in_ready !== !(occ == 4 && !ifd.out_ready)) begin
                errors++; $display("FAIL rnd_in_ready: got %b with occupancy %0d", ifd.in_ready, occ); end
            inx  = ifd.in_valid && ifd.in_ready;
            outx = ifd.out_valid && ifd.out_ready;
            if (outx) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_extra_word: got %h with empty queue", ifd.out_data); end
                else begin
                    e = q.pop_front();
                    if ({24'd0, ifd.out_data} !== e.d || {24'd0, ifd.out_inc} !== e.i || ifd.out_ovf !== e.o) begin
                        errors++; $display("FAIL rnd_word: got %h/%h/%b expected %h/%h/%b", ifd.out_data, ifd.out_inc, ifd.out_ovf, e.d[7:0], e.i[7:0], e.o); end
                end
                got++;
            end
            if (inx) begin q.push_back(model({24'd0, ifd.in_data}, 8, 5, 1'b1)); sent++; end
            occ = occ + int'(inx) - int'(outx);
            step();
        end
        ifd.in_valid = 1'b0;
        checks++; if (got !== 1000 || q.size() !== 0) begin
            errors++; $display("FAIL rnd_total: got %0d words %0d pending expected 1000/0", got, q.size()); end
    endtask

    initial begin
        test_reset();
        test_small_incr();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
